ballot_session_ctrl: RTL
========================

// Module: ballot_session_ctrl
// PURPOSE
// - Sequences one voter per session in front of the voting-machine vote counters.
// - Lets the officer arm the booth and debounces the four candidate buttons.
// - Rejects simultaneous presses and emits exactly one vote_valid/vote_sel strobe per armed session.
// - Times out abandoned sessions. Locks the booth while mode=1 (results display).
// PARAMETERS
// - DEBOUNCE_CYCLES   default 10    cycles a single button must stay stable before the vote is cast (>=1)
// - TIMEOUT_CYCLES    default 1000  cycles in ARMED+REJECT before the session is abandoned (>=2)
// - CNT_W             default 8     width of the voters counter
// PORTS
// - clock     in   1      system clock, rising edge
// - reset     in   1      asynchronous, active-high reset
// - mode      in   1      1 = results display; booth locked
// - arm       in   1      officer enable; rising edge starts a session
// - button1   in   1      candidate 0 press
// - button2   in   1      candidate 1 press
// - button3   in   1      candidate 2 press
// - button4   in   1      candidate 3 press
// - vote_valid  out  1      one-cycle strobe: count one vote for vote_sel
// - vote_sel    out  2      candidate index (0..3); 0 whenever vote_valid=0
// - armed       out  1      high in ARMED, DEBOUNCE, REJECT
// - reject      out  1      one-cycle pulse on entry to REJECT
// - timeout     out  1      one-cycle pulse when a session is abandoned
// - voters      out  CNT_W  sessions completed with a vote; saturates at all-ones
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, btn_q=0, arm_q=0.
// - Input sampling: btn_q = {button4..button1} and arm_q are registered every cycle.
//   - All decisions use btn_q. arm_rise = arm & ~arm_q.
// - mode=1: forces IDLE next cycle from any state, overriding every transition below.
//   - No vote_valid, reject or timeout pulse is generated; arm_rise is ignored while mode=1.
// - IDLE: go to ARMED when arm_rise & ~mode & (btn_q==0). Otherwise stay.
//   - An arm edge while a button is held is dropped.
// - ARMED: clear tmr on entry from IDLE only.
//   - btn_q one-hot: go to DEBOUNCE, latch cand=btn_q, dcnt=0.
//   - btn_q multi-hot: go to REJECT.
//   - tmr==TIMEOUT_CYCLES-1: go to IDLE and pulse timeout. A same-cycle press is ignored.
// - DEBOUNCE: tmr is frozen.
//   - btn_q==cand: dcnt++. At dcnt==DEBOUNCE_CYCLES-1, go to CAST.
//   - btn_q==0: go back to ARMED (glitch), no pulse.
//   - Any other value (changed or added button): go to REJECT.
// - CAST (1 cycle): vote_valid=1, vote_sel=onehot2bin(cand), voters++ unless saturated. Then go to RELEASE.
// - RELEASE: wait for btn_q==0, then go to IDLE. No timeout here.
// - REJECT: reject pulses in the entry cycle; tmr keeps counting.
//   - btn_q==0: go to ARMED.
//   - tmr expiry: go to IDLE and pulse timeout.
// - Latency: a single held press first sampled at edge N makes vote_valid high
//   in the cycle after edge N+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles after sampling.
// - Exactly one vote_valid per arm_rise accepted. A new session needs a fresh arm rising edge.
// - Reset mid-session: immediate return to IDLE, no strobe. voters cleared.
// STRUCTURE
// - voting_pkg (shared):
//   - NUM_CAND=4, CAND_W=2
//   - ballot_state_t enum {IDLE, ARMED, DEBOUNCE, CAST, RELEASE, REJECT}
//   - onehot2bin function
// - Sub-module ballot_timer: TIMEOUT counter with clear/enable/expire.
// - FSM, debounce counter and voters counter live in ballot_session_ctrl.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
// 1. Reset, arm pulse, button1 held 20 cycles, then released.
//    -> exactly 1 vote_valid, vote_sel=0, voters=1, armed low after CAST.
// 2. Arm, button2+button3 together.
//    -> reject=1 for 1 cycle, no vote_valid.
//    -> Release, then button3 held 10 cycles -> vote_sel=2, voters=1.
// 3. Arm, button4 high for 2 cycles, then low.
//    -> no vote_valid, armed stays 1.
//    -> Then button4 held 10 cycles -> vote_sel=3.
// 4. Arm, no press for 50 cycles.
//    -> timeout pulse, armed=0.
//    -> A following button1 press with no arm -> no vote_valid.
// 5. Arm, button2 held; mode=1 during DEBOUNCE.
//    -> IDLE, no vote_valid.
//    -> Arm edge while mode=1 ignored, armed stays 0.
// 6. 256 complete sessions with CNT_W=8.
//    -> voters saturates at 255.
//    -> Reset asserted mid-DEBOUNCE -> all outputs 0 immediately.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared types and helpers for the ballot booth controller.
package voting_pkg;

  localparam int NUM_CAND = 4;
  localparam int CAND_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DEBOUNCE,
    CAST,
    RELEASE,
    REJECT
  } ballot_state_t;

  // Encoded index of a one-hot candidate vector (caller guarantees one-hot).
  function automatic logic [CAND_W-1:0] onehot2bin(input logic [NUM_CAND-1:0] oh);
    logic [CAND_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (oh[i]) b = b | CAND_W'(i);
    return b;
  endfunction

endpackage

// File: rtl/ballot_session_ctrl_if.sv
// Booth I/O bundle: officer/voter inputs towards the controller, vote strobe
// and status towards the counters and display.
interface ballot_session_ctrl_if #(parameter int CNT_W = 8);
  import voting_pkg::*;

  logic              mode;
  logic              arm;
  logic              button1;
  logic              button2;
  logic              button3;
  logic              button4;
  logic              vote_valid;
  logic [CAND_W-1:0] vote_sel;
  logic              armed;
  logic              reject;
  logic              timeout;
  logic [CNT_W-1:0]  voters;

  modport master (
    output mode, arm, button1, button2, button3, button4,
    input  vote_valid, vote_sel, armed, reject, timeout, voters
  );

  modport slave (
    input  mode, arm, button1, button2, button3, button4,
    output vote_valid, vote_sel, armed, reject, timeout, voters
  );
endinterface

// File: rtl/ballot_timer.sv
// Session timeout counter: cleared while idle, counts only while enabled,
// and parks at the terminal value so expire_o stays asserted.
module ballot_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmr_q;

  assign expire_o = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  // Count up while enabled, hold at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmr_q <= '0;
    else if (clr_i)             tmr_q <= '0;
    else if (en_i && !expire_o) tmr_q <= tmr_q + 1'b1;
  end
endmodule

// File: rtl/ballot_session_ctrl.sv
// One-voter-per-session sequencer: arm, debounce one candidate button,
// reject multi-presses, time out abandoned sessions, lock during results.
module ballot_session_ctrl
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  ballot_session_ctrl_if.slave bus
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  ballot_state_t     state_q;
  logic [NUM_CAND-1:0] btn_q, cand_q, btn_raw;
  logic              arm_q, arm_rise;
  logic [DW-1:0]     dcnt_q;
  logic [CNT_W-1:0]  voters_q;
  logic              vote_valid_q, armed_q, reject_q, timeout_q;
  logic [CAND_W-1:0] vote_sel_q;
  logic              tmr_expire;

  assign btn_raw  = {bus.button4, bus.button3, bus.button2, bus.button1};
  assign arm_rise = bus.arm & ~arm_q;

  // Timer runs only in ARMED/REJECT; clearing it while idle gives a fresh
  // budget on every IDLE->ARMED entry but not on REJECT->ARMED returns.
  ballot_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clock),
    .rst      (reset),
    .clr_i    (state_q == IDLE),
    .en_i     ((state_q == ARMED) || (state_q == REJECT)),
    .expire_o (tmr_expire)
  );

  // Session FSM with input sampling, debounce/voter counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      btn_q        <= '0;
      arm_q        <= 1'b0;
      cand_q       <= '0;
      dcnt_q       <= '0;
      voters_q     <= '0;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= '0;
      armed_q      <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      btn_q        <= btn_raw;
      arm_q        <= bus.arm;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= '0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      if (bus.mode) begin
        // Results display locks the booth regardless of session progress.
        state_q <= IDLE;
        armed_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (arm_rise && (btn_q == '0)) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
          end
          ARMED: begin
            if (tmr_expire) begin
              state_q   <= IDLE;
              armed_q   <= 1'b0;
              timeout_q <= 1'b1;
            end else if ($onehot(btn_q)) begin
              state_q <= DEBOUNCE;
              cand_q  <= btn_q;
              dcnt_q  <= '0;
            end else if (btn_q != '0) begin
              state_q  <= REJECT;
              reject_q <= 1'b1;
            end
          end
          DEBOUNCE: begin
            if (btn_q == cand_q) begin
              if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                state_q      <= CAST;
                armed_q      <= 1'b0;
                vote_valid_q <= 1'b1;
                vote_sel_q   <= onehot2bin(cand_q);
                if (voters_q != '1) voters_q <= voters_q + 1'b1;
              end else begin
                dcnt_q <= dcnt_q + 1'b1;
              end
            end else if (btn_q == '0) begin
              state_q <= ARMED;
            end else begin
              state_q  <= REJECT;
              reject_q <= 1'b1;
            end
          end
          CAST:    state_q <= RELEASE;
          RELEASE: if (btn_q == '0) state_q <= IDLE;
          REJECT: begin
            if (tmr_expire) begin
              state_q   <= IDLE;
              armed_q   <= 1'b0;
              timeout_q <= 1'b1;
            end else if (btn_q == '0) begin
              state_q <= ARMED;
            end
          end
          default: begin
            state_q <= IDLE;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.vote_valid = vote_valid_q;
  assign bus.vote_sel   = vote_sel_q;
  assign bus.armed      = armed_q;
  assign bus.reject     = reject_q;
  assign bus.timeout    = timeout_q;
  assign bus.voters     = voters_q;
endmodule
